// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the instruction fetch unit
//
// Purpose : common definitions imported by fetch_unit_if, fetch_fifo and fetch_unit.
// Contents: XLEN, INSTR_NOP, fetch_state_e, fetch_entry_t, align_word().
// Ports   : none (package).
// Macro   : FETCH_MISALIGN_CHECK_EN is consumed by the interface and the top, not here.

package fetch_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

   typedef enum logic {
      FETCH = 1'b0,
      HALT  = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // Clear the byte offset so an address always names a full instruction word.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - memory, decode and redirect signal bundle of the fetch unit
//
// Purpose : groups every handshake/bus signal of fetch_unit; clk/rst_n stay plain ports.
// Modports: master = fetch unit side, slave = memory/decode/PC-logic side.
// Signals :
//   mem_req_valid  fetch request valid           (master -> slave)
//   mem_req_ready  memory accepts request        (slave  -> master)
//   mem_addr       word-aligned fetch address    (master -> slave)
//   mem_rsp_valid  in-order response valid       (slave  -> master)
//   mem_rsp_data   instruction word              (slave  -> master)
//   instr_valid    buffer head valid             (master -> slave)
//   instr_ready    decode consumes head          (slave  -> master)
//   instr          head instruction              (master -> slave)
//   instr_pc       head instruction address      (master -> slave)
//   redirect       flush and restart             (slave  -> master)
//   redirect_pc    restart address               (slave  -> master)
//   misalign_err   misaligned redirect target, only with FETCH_MISALIGN_CHECK_EN

interface fetch_unit_if;
   import fetch_pkg::*;

   logic            mem_req_valid;
   logic            mem_req_ready;
   logic [XLEN-1:0] mem_addr;
   logic            mem_rsp_valid;
   logic [XLEN-1:0] mem_rsp_data;
   logic            instr_valid;
   logic            instr_ready;
   logic [XLEN-1:0] instr;
   logic [XLEN-1:0] instr_pc;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic            misalign_err;
`endif

   modport master (
      output mem_req_valid,
      output mem_addr,
      input  mem_req_ready,
      input  mem_rsp_valid,
      input  mem_rsp_data,
      output instr_valid,
      output instr,
      output instr_pc,
      input  instr_ready,
`ifdef FETCH_MISALIGN_CHECK_EN
      output misalign_err,
`endif
      input  redirect,
      input  redirect_pc
   );

   modport slave (
      input  mem_req_valid,
      input  mem_addr,
      output mem_req_ready,
      output mem_rsp_valid,
      output mem_rsp_data,
      input  instr_valid,
      input  instr,
      input  instr_pc,
      output instr_ready,
`ifdef FETCH_MISALIGN_CHECK_EN
      input  misalign_err,
`endif
      output redirect,
      output redirect_pc
   );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO of fetch_entry_t with flush
//
// Purpose : used twice by fetch_unit, as the in-flight PC tag queue and as the
//           instruction buffer presented to decode.
// Ports   :
//   clk, rst_n  clock, asynchronous active-low reset
//   flush       empties the FIFO; wins over push/pop in the same cycle
//   push        write push_data (ignored when full unless a pop frees a slot)
//   push_data   entry to write
//   pop         drop the head entry (ignored when empty)
//   head        oldest entry (contents undefined while count == 0)
//   count       number of valid entries, 0..DEPTH

module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  fetch_entry_t               push_data,
   input  logic                       pop,
   output fetch_entry_t               head,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int            CW   = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PW'(1);
   endfunction

   // A full FIFO may still take a push when the head leaves in the same cycle.
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage carries no reset; readers qualify head with count.
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - sequential instruction fetch with credit-limited issue and redirect flush
//
// Purpose : issues word-aligned fetch addresses to the instruction memory, matches the
//           in-order responses with their PCs and presents {pc, instr} to decode.
// Params  : RESET_PC  (fetch address after reset, 4-byte aligned)
//           BUF_DEPTH (instruction buffer entries and in-flight credit limit, >= 1)
// Ports   : clk, rst_n (asynchronous active-low)
//           bus (fetch_unit_if.master): mem_req_*/mem_addr request channel,
//           mem_rsp_* response channel, instr_* decode channel, redirect/redirect_pc,
//           misalign_err when FETCH_MISALIGN_CHECK_EN is defined.
// Macro   : FETCH_MISALIGN_CHECK_EN - misaligned redirect halts fetch and raises a sticky
//           misalign_err until the next aligned redirect; otherwise the target's low two
//           bits are simply cleared.

module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter int              BUF_DEPTH = 2
) (
   input logic          clk,
   input logic          rst_n,
   fetch_unit_if.master bus
);

   localparam int            CW      = $clog2(BUF_DEPTH + 1);
   localparam logic [CW:0]   DEPTH_C = (CW + 1)'(BUF_DEPTH);

   fetch_state_e    state;
   logic [XLEN-1:0] fetch_pc;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   drop;
   logic [CW-1:0]   buf_count;
   logic [CW-1:0]   tag_count;
   logic [CW:0]     credit_used;
   logic            live;
   logic            req_valid;
   logic            accept;
   logic            rsp_seen;
   logic            rsp_keep;
   logic            dec_pop;
   logic            misalign;
   logic [XLEN-1:0] target;
   fetch_entry_t    tag_in;
   fetch_entry_t    tag_head;
   fetch_entry_t    buf_in;
   fetch_entry_t    buf_head;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic            misalign_err_q;
`endif

`ifdef FETCH_MISALIGN_CHECK_EN
   assign misalign         = (bus.redirect_pc[1:0] != 2'b00);
   assign bus.misalign_err = misalign_err_q;
`else
   assign misalign = 1'b0;
`endif
   assign target = align_word(bus.redirect_pc);

   // Every entry either in flight or sitting in the buffer holds one credit, so a
   // response can always be written without overflowing the buffer.
   assign credit_used = {1'b0, inflight} + {1'b0, buf_count};
   assign req_valid   = live && (state == FETCH) && !bus.redirect && (credit_used < DEPTH_C);
   assign accept      = req_valid && bus.mem_req_ready;

   // Responses with nothing outstanding are leftovers from before a reset.
   assign rsp_seen = bus.mem_rsp_valid && (inflight != '0);
   assign rsp_keep = rsp_seen && (drop == '0) && !bus.redirect && (tag_count != '0);
   assign dec_pop  = bus.instr_valid && bus.instr_ready && !bus.redirect;

   assign tag_in = '{pc: fetch_pc, instr: INSTR_NOP};

   always_comb begin
      buf_in       = tag_head;
      buf_in.instr = bus.mem_rsp_data;
   end

   fetch_fifo #(.DEPTH(BUF_DEPTH)) u_tag_q (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (bus.redirect),
      .push      (accept),
      .push_data (tag_in),
      .pop       (rsp_keep),
      .head      (tag_head),
      .count     (tag_count)
   );

   fetch_fifo #(.DEPTH(BUF_DEPTH)) u_instr_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (bus.redirect),
      .push      (rsp_keep),
      .push_data (buf_in),
      .pop       (dec_pop),
      .head      (buf_head),
      .count     (buf_count)
   );

   assign bus.mem_req_valid = req_valid;
   assign bus.mem_addr      = fetch_pc;
   assign bus.instr_valid   = (buf_count != '0);
   assign bus.instr         = bus.instr_valid ? buf_head.instr : '0;
   assign bus.instr_pc      = bus.instr_valid ? buf_head.pc : '0;

   // live holds off the first request until one clock after reset release, which keeps
   // mem_req_valid low for the whole reset period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FETCH;
         fetch_pc <= RESET_PC;
         inflight <= '0;
         drop     <= '0;
         live     <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
         misalign_err_q <= 1'b0;
`endif
      end else begin
         live     <= 1'b1;
         inflight <= inflight + CW'(accept) - CW'(rsp_seen);
         if (bus.redirect) begin
            // Everything still outstanding after this cycle belongs to the old stream.
            fetch_pc <= target;
            drop     <= inflight - CW'(rsp_seen);
            state    <= misalign ? HALT : FETCH;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_err_q <= misalign;
`endif
         end else begin
            if (accept) begin
               fetch_pc <= fetch_pc + 32'd4;
            end
            if (rsp_seen && (drop != '0)) begin
               drop <= drop - CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomised scoreboard bench for fetch_unit

module tb_fetch_unit;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   fetch_unit_if bus ();

   fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .BUF_DEPTH (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          n_acc    = 0;
   int          n_pop    = 0;
   int          last_due = 0;
   int          lat_min  = 1;
   int          lat_max  = 1;
   bit          rnd_ready = 1'b0;
   bit          rnd_ir    = 1'b0;
   bit          hold_mem  = 1'b0;
   bit          redir     = 1'b0;
   bit          popped    = 1'b0;
   bit          rsp_drv   = 1'b0;
   logic        ir_val    = 1'b0;
   logic [31:0] redir_pc  = '0;
   logic [31:0] model_pc  = '0;
   logic [31:0] last_pop_pc = '0;

   logic [63:0] exp_q [$];
   logic [31:0] pend_addr [$];
   int          pend_due [$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs at negedge, observe handshakes that complete at the next posedge.
   task automatic step();
      int          due;
      logic [63:0] e;
      @(negedge clk);
      cyc++;
      rsp_drv = 1'b0;
      if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
         bus.mem_rsp_valid = 1'b1;
         bus.mem_rsp_data  = mem_word(pend_addr.pop_front());
         void'(pend_due.pop_front());
         rsp_drv = 1'b1;
      end else begin
         bus.mem_rsp_valid = 1'b0;
         bus.mem_rsp_data  = $urandom;
      end
      bus.mem_req_ready = hold_mem ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      bus.instr_ready   = rnd_ir ? 1'($urandom_range(0, 1)) : ir_val;
      bus.redirect      = redir;
      bus.redirect_pc   = redir_pc;
      #1;
      if (!redir && bus.instr_valid && bus.instr_ready) begin
         n_pop++;
         popped      = 1'b1;
         last_pop_pc = bus.instr_pc;
         chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_instr_pc", bus.instr_pc, e[63:32]);
            chk("sb_instr", bus.instr, e[31:0]);
         end
      end
      if (bus.mem_req_valid && bus.mem_req_ready) begin
         n_acc++;
         chk("mem_addr", bus.mem_addr, model_pc);
         exp_q.push_back({model_pc, mem_word(model_pc)});
         pend_addr.push_back(bus.mem_addr);
         due = cyc + int'($urandom_range(lat_min, lat_max));
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         pend_due.push_back(due);
         model_pc = model_pc + 32'd4;
      end
      if (redir) begin
         chk("redir_no_req", 32'(bus.mem_req_valid), 32'd0);
         exp_q.delete();
         model_pc = redir_pc & 32'hFFFF_FFFC;
      end
   endtask

   task automatic run_until_pop(input string tag);
      int k = 0;
      popped = 1'b0;
      while (!popped && k < 100) begin
         step();
         k++;
      end
      chk({tag, "_pop_timeout"}, 32'(popped), 32'd1);
   endtask

   task automatic drain();
      int k = 0;
      hold_mem = 1'b1;
      rnd_ready = 1'b0;
      rnd_ir = 1'b0;
      ir_val = 1'b1;
      redir = 1'b0;
      while ((exp_q.size() != 0 || pend_addr.size() != 0) && k < 300) begin
         step();
         k++;
      end
      chk("drain_empty", 32'(exp_q.size() + pend_addr.size()), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0;
      int p0;
      int k;
      int t_rsp;
      bit seen;

      // Reset, with a redirect that must be ignored while reset is held.
      rst_n = 1'b0;
      bus.mem_req_ready = 1'b1;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
      bus.instr_ready   = 1'b1;
      bus.redirect      = 1'b1;
      bus.redirect_pc   = 32'h0000_0500;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0000_0000);
      chk("rst_instr", bus.instr, 32'h0000_0000);
      chk("rst_instr_pc", bus.instr_pc, 32'h0000_0000);
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("rst_misalign", 32'(bus.misalign_err), 32'd0);
`endif
      @(negedge clk);
      bus.redirect = 1'b0;
      rst_n = 1'b1;

      // 1: sequential stream from RESET_PC, one-cycle response latency.
      ir_val = 1'b1;
      t_rsp = -1;
      seen = 1'b0;
      k = 0;
      while (!seen && k < 20) begin
         step();
         k++;
         if (rsp_drv && t_rsp < 0) t_rsp = cyc;
         if (bus.instr_valid) seen = 1'b1;
      end
      chk("t1_seen", 32'(seen), 32'd1);
      chk("t1_latency", 32'(cyc - t_rsp), 32'd1);
      chk("t1_first_pc", last_pop_pc, 32'h0000_0000);
      repeat (12) step();
      chk("t1_progress", 32'(n_pop >= 5), 32'd1);

      // 2: decode stalled -> only BUF_DEPTH requests, then resume without loss.
      drain();
      hold_mem = 1'b0;
      ir_val = 1'b0;
      a0 = n_acc;
      repeat (10) step();
      chk("t2_reqs", 32'(n_acc - a0), 32'd2);
      chk("t2_req_valid", 32'(bus.mem_req_valid), 32'd0);
      chk("t2_instr_valid", 32'(bus.instr_valid), 32'd1);
      ir_val = 1'b1;
      p0 = n_pop;
      repeat (10) step();
      chk("t2_resume", 32'(n_pop - p0 >= 4), 32'd1);

      // 3: redirect with two requests in flight.
      drain();
      hold_mem = 1'b0;
      lat_min = 4;
      lat_max = 4;
      a0 = n_acc;
      step();
      step();
      chk("t3_inflight", 32'(n_acc - a0), 32'd2);
      redir = 1'b1;
      redir_pc = 32'h0000_0100;
      step();
      redir = 1'b0;
      lat_min = 1;
      lat_max = 1;
      run_until_pop("t3");
      chk("t3_first_pc", last_pop_pc, 32'h0000_0100);

      // 4: redirect coinciding with a response and a decode handshake.
      drain();
      hold_mem = 1'b0;
      ir_val = 1'b0;
      step();
      step();
      redir = 1'b1;
      redir_pc = 32'h0000_0200;
      ir_val = 1'b1;
      step();
      chk("t4_rsp_driven", 32'(rsp_drv), 32'd1);
      chk("t4_head_valid", 32'(bus.instr_valid), 32'd1);
      redir = 1'b0;
      step();
      chk("t4_flushed", 32'(bus.instr_valid), 32'd0);
      run_until_pop("t4");
      chk("t4_first_pc", last_pop_pc, 32'h0000_0200);

      // 5: PC wrap.
      drain();
      hold_mem = 1'b0;
      redir = 1'b1;
      redir_pc = 32'hFFFF_FFF8;
      step();
      redir = 1'b0;
      run_until_pop("t5a");
      chk("t5_pc0", last_pop_pc, 32'hFFFF_FFF8);
      run_until_pop("t5b");
      chk("t5_pc1", last_pop_pc, 32'hFFFF_FFFC);
      run_until_pop("t5c");
      chk("t5_pc2", last_pop_pc, 32'h0000_0000);

      // 6: misaligned redirect target.
      drain();
      hold_mem = 1'b0;
      redir = 1'b1;
      redir_pc = 32'h0000_0102;
      step();
      redir = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      a0 = n_acc;
      repeat (8) step();
      chk("t6_no_req", 32'(n_acc - a0), 32'd0);
      chk("t6_err", 32'(bus.misalign_err), 32'd1);
      chk("t6_halt_req_valid", 32'(bus.mem_req_valid), 32'd0);
      redir = 1'b1;
      redir_pc = 32'h0000_0300;
      step();
      redir = 1'b0;
      step();
      chk("t6_err_clear", 32'(bus.misalign_err), 32'd0);
      run_until_pop("t6");
      chk("t6_first_pc", last_pop_pc, 32'h0000_0300);
`else
      run_until_pop("t6");
      chk("t6_first_pc", last_pop_pc, 32'h0000_0100);
`endif

      // Random ready/latency/decode with occasional aligned redirects.
      drain();
      hold_mem = 1'b0;
      rnd_ready = 1'b1;
      rnd_ir = 1'b1;
      lat_min = 1;
      lat_max = 4;
      p0 = n_pop;
      for (int i = 0; i < 800; i++) begin
         redir = ($urandom_range(0, 39) == 0);
         redir_pc = $urandom & 32'hFFFF_FFFC;
         step();
      end
      redir = 1'b0;
      drain();
      chk("rand_progress", 32'(n_pop - p0 > 100), 32'd1);

      // Reset while requests are in flight; their late responses must be discarded.
      hold_mem = 1'b0;
      ir_val = 1'b0;
      lat_min = 6;
      lat_max = 6;
      a0 = n_acc;
      step();
      step();
      chk("t7_inflight", 32'(n_acc - a0), 32'd2);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      hold_mem = 1'b1;
      step();
      step();
      chk("t7_rst_instr_valid", 32'(bus.instr_valid), 32'd0);
      chk("t7_rst_mem_addr", bus.mem_addr, 32'h0000_0000);
      rst_n = 1'b1;
      exp_q.delete();
      model_pc = 32'h0000_0000;
      ir_val = 1'b1;
      repeat (10) step();
      chk("t7_stale_dropped", 32'(bus.instr_valid), 32'd0);
      chk("t7_mem_drained", 32'(pend_addr.size()), 32'd0);
      hold_mem = 1'b0;
      lat_min = 1;
      lat_max = 1;
      run_until_pop("t7");
      chk("t7_first_pc", last_pop_pc, 32'h0000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
